// File: rtl/simplez_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simplez_pkg
// Description : Shared definitions for the Simplez control sequencer:
//               machine widths, opcode and sequencer-state encodings and the
//               packed microorder bundle produced by the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package simplez_pkg;

  localparam int DATAW = 12;
  localparam int ADDRW = 9;

  // RI[11:9] operation codes
  typedef enum logic [2:0] {
    OP_ST   = 3'd0,
    OP_LD   = 3'd1,
    OP_ADD  = 3'd2,
    OP_BR   = 3'd3,
    OP_BZ   = 3'd4,
    OP_CLR  = 3'd5,
    OP_DEC  = 3'd6,
    OP_HALT = 3'd7
  } opcode_t;

  // Sequencer states; code 3'd7 is unused and recovers to S_INIT
  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_I0     = 3'd1,
    S_I1     = 3'd2,
    S_O0     = 3'd3,
    S_O1     = 3'd4,
    S_PAUSE  = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  // Datapath microorders, one bit each
  typedef struct packed {
    logic lec;
    logic esc;
    logic era;
    logic eri;
    logic sri;
    logic incp;
    logic ecp;
    logic ccp;
    logic scp;
    logic eac;
    logic sac;
    logic sum;
    logic tra2;
    logic dec1;
    logic bor;
  } uorders_t;

endpackage : simplez_pkg
`default_nettype wire

// File: rtl/simplez_if.sv
`default_nettype none
// ============================================================================
// Module      : simplez_if
// Description : Bus between the Simplez datapath/front panel and the control
//               sequencer.
//   Inputs to sequencer : opcode, ac_zero, run, step_mode
//   Outputs             : 15 microorders, stop, state, icount[ICW-1:0]
//   master modport      : datapath / front-panel side
//   slave modport       : sequencer side
// Revision    : 1.0 - initial release
// ============================================================================
interface simplez_if #(
  parameter int ICW = 16
);
  import simplez_pkg::*;

  opcode_t        opcode;
  logic           ac_zero;
  logic           run;
  logic           step_mode;

  logic           lec, esc, era, eri, sri, incp, ecp, ccp;
  logic           scp, eac, sac, sum, tra2, dec1, bor;
  logic           stop;
  state_t         state;
  logic [ICW-1:0] icount;

  modport master (
    output opcode, ac_zero, run, step_mode,
    input  lec, esc, era, eri, sri, incp, ecp, ccp,
    input  scp, eac, sac, sum, tra2, dec1, bor,
    input  stop, state, icount
  );

  modport slave (
    input  opcode, ac_zero, run, step_mode,
    output lec, esc, era, eri, sri, incp, ecp, ccp,
    output scp, eac, sac, sum, tra2, dec1, bor,
    output stop, state, icount
  );

endinterface : simplez_if
`default_nettype wire

// File: rtl/simplez_udecode.sv
`default_nettype none
// ============================================================================
// Module      : simplez_udecode
// Description : Purely combinational microorder decoder.
//   state      : current sequencer state
//   opcode     : live opcode (decoded during I1)
//   opcode_lat : opcode captured at instruction fetch (decoded during O0)
//   ac_zero    : accumulator-is-zero flag (BZ decision in I1)
//   uo         : 15 datapath microorders
// Revision    : 1.0 - initial release
// ============================================================================
module simplez_udecode
  import simplez_pkg::*;
(
  input  state_t   state,
  input  opcode_t  opcode,
  input  opcode_t  opcode_lat,
  input  logic     ac_zero,
  output uorders_t uo
);

  always_comb begin
    uo = '0;
    case (state)
      S_INIT: uo.ccp = 1'b1;
      S_I0: begin
        uo.lec  = 1'b1;
        uo.eri  = 1'b1;
        uo.incp = 1'b1;
      end
      S_I1: begin
        case (opcode)
          OP_ST, OP_LD, OP_ADD: begin
            uo.sri = 1'b1;
            uo.era = 1'b1;
          end
          OP_BR: begin
            uo.sri = 1'b1;
            uo.era = 1'b1;
            uo.ecp = 1'b1;
          end
          OP_BZ: begin
            // Taken branch loads the target from RI; otherwise fetch from CP
            uo.era = 1'b1;
            if (ac_zero) begin
              uo.sri = 1'b1;
              uo.ecp = 1'b1;
            end else begin
              uo.scp = 1'b1;
            end
          end
          OP_CLR: begin
            uo.bor = 1'b1;
            uo.eac = 1'b1;
            uo.scp = 1'b1;
            uo.era = 1'b1;
          end
          OP_DEC: begin
            uo.dec1 = 1'b1;
            uo.eac  = 1'b1;
            uo.scp  = 1'b1;
            uo.era  = 1'b1;
          end
          default: ; // HALT: no microorders
        endcase
      end
      S_O0: begin
        // The operand phase follows the opcode captured at fetch, not the
        // live bus value, which may already have moved on.
        case (opcode_lat)
          OP_ST: begin
            uo.sac = 1'b1;
            uo.esc = 1'b1;
          end
          OP_LD: begin
            uo.lec  = 1'b1;
            uo.tra2 = 1'b1;
            uo.eac  = 1'b1;
          end
          OP_ADD: begin
            uo.lec = 1'b1;
            uo.sum = 1'b1;
            uo.eac = 1'b1;
          end
          default: ;
        endcase
      end
      S_O1: begin
        uo.scp = 1'b1;
        uo.era = 1'b1;
      end
      default: ; // PAUSE, HALTED, unused code
    endcase
  end

endmodule : simplez_udecode
`default_nettype wire

// File: rtl/simplez_seq.sv
`default_nettype none
// ============================================================================
// Module      : simplez_seq
// Description : Simplez control sequencer. Holds the state register, the
//               fetched-opcode latch and the retired-instruction counter; all
//               state advances on the falling edge of clk.
//   clk  : clock (falling edge active)
//   rst  : synchronous active-high reset
//   bus  : simplez_if.slave - opcode/ac_zero/run/step_mode in,
//          microorders/stop/state/icount out
// Revision    : 1.0 - initial release
// ============================================================================
module simplez_seq
  import simplez_pkg::*;
#(
  parameter int ICW = 16
) (
  input  logic      clk,
  input  logic      rst,
  simplez_if.slave  bus
);

  localparam logic [ICW-1:0] ICOUNT_INC = {{(ICW-1){1'b0}}, 1'b1};

  state_t         state_r;
  state_t         state_nxt;
  state_t         fetch_state;
  opcode_t        opcode_lat_r;
  logic [ICW-1:0] icount_r;
  uorders_t       uo;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(negedge clk) begin
    if (rst) begin
      state_r <= S_INIT;
    end else begin
      state_r <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // Where the next instruction begins: straight into I0, or park in PAUSE
    fetch_state = bus.step_mode ? S_PAUSE : S_I0;
    state_nxt   = S_INIT;
    case (state_r)
      S_INIT: state_nxt = S_O1;
      S_I0:   state_nxt = S_I1;
      S_I1: begin
        case (bus.opcode)
          OP_ST, OP_LD, OP_ADD: state_nxt = S_O0;
          OP_HALT:              state_nxt = S_HALTED;
          default:              state_nxt = fetch_state;
        endcase
      end
      S_O0:     state_nxt = S_O1;
      S_O1:     state_nxt = fetch_state;
      S_PAUSE:  state_nxt = bus.run ? S_I0 : S_PAUSE;
      // Leaving HALTED goes through O1 so the address bus reloads from CP
      S_HALTED: state_nxt = bus.run ? S_O1 : S_HALTED;
      default:  state_nxt = S_INIT;
    endcase
  end

  // --------------------------------------------------------------------------
  // Opcode latch and retired-instruction counter
  // --------------------------------------------------------------------------
  always_ff @(negedge clk) begin
    if (rst) begin
      opcode_lat_r <= OP_ST;
      icount_r     <= '0;
    end else begin
      if (state_r == S_I0) begin
        opcode_lat_r <= bus.opcode;
      end
      // Every instruction passes through I1 exactly once, HALT included
      if (state_r == S_I1) begin
        icount_r <= icount_r + ICOUNT_INC;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Microorder decoder
  // --------------------------------------------------------------------------
  simplez_udecode u_udecode (
    .state      (state_r),
    .opcode     (bus.opcode),
    .opcode_lat (opcode_lat_r),
    .ac_zero    (bus.ac_zero),
    .uo         (uo)
  );

  assign bus.lec    = uo.lec;
  assign bus.esc    = uo.esc;
  assign bus.era    = uo.era;
  assign bus.eri    = uo.eri;
  assign bus.sri    = uo.sri;
  assign bus.incp   = uo.incp;
  assign bus.ecp    = uo.ecp;
  assign bus.ccp    = uo.ccp;
  assign bus.scp    = uo.scp;
  assign bus.eac    = uo.eac;
  assign bus.sac    = uo.sac;
  assign bus.sum    = uo.sum;
  assign bus.tra2   = uo.tra2;
  assign bus.dec1   = uo.dec1;
  assign bus.bor    = uo.bor;
  assign bus.stop   = (state_r == S_HALTED);
  assign bus.state  = state_r;
  assign bus.icount = icount_r;

endmodule : simplez_seq
`default_nettype wire

// File: tb/tb_simplez_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_simplez_seq
// Description : Self-checking bench for simplez_seq. Two instances run in
//               lock-step (ICW=16 and ICW=4). Each scenario task builds a
//               per-cycle table of inputs and expected outputs; expectations
//               are queued as stimulus is driven and popped when sampled.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_simplez_seq;
  import simplez_pkg::*;

  localparam logic [14:0] LEC  = 15'h4000;
  localparam logic [14:0] ESC  = 15'h2000;
  localparam logic [14:0] ERA  = 15'h1000;
  localparam logic [14:0] ERI  = 15'h0800;
  localparam logic [14:0] SRI  = 15'h0400;
  localparam logic [14:0] INCP = 15'h0200;
  localparam logic [14:0] ECP  = 15'h0100;
  localparam logic [14:0] CCP  = 15'h0080;
  localparam logic [14:0] SCP  = 15'h0040;
  localparam logic [14:0] EAC  = 15'h0020;
  localparam logic [14:0] SAC  = 15'h0010;
  localparam logic [14:0] SUM  = 15'h0008;
  localparam logic [14:0] TRA2 = 15'h0004;
  localparam logic [14:0] DEC1 = 15'h0002;
  localparam logic [14:0] BOR  = 15'h0001;
  localparam logic [14:0] NONE = 15'h0000;

  // One clock cycle of stimulus plus the outputs expected during it
  typedef struct packed {
    logic        rst;
    logic [2:0]  op;
    logic        az;
    logic        run;
    logic        step;
    logic [2:0]  st;
    logic [14:0] uo;
    logic        stop;
  } cyc_t;

  // {state, microorders, stop, icount16, state4, icount4}
  typedef logic [41:0] obs_t;

  logic    clk = 1'b1;
  logic    rst = 1'b1;
  opcode_t opcode = OP_ST;
  logic    ac_zero = 1'b0;
  logic    run = 1'b0;
  logic    step_mode = 1'b0;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_ic = '0;
  obs_t        sb[$];

  always #5 clk = ~clk;

  simplez_if #(.ICW(16)) bus ();
  simplez_if #(.ICW(4))  bus4 ();

  assign bus.opcode     = opcode;
  assign bus.ac_zero    = ac_zero;
  assign bus.run        = run;
  assign bus.step_mode  = step_mode;
  assign bus4.opcode    = opcode;
  assign bus4.ac_zero   = ac_zero;
  assign bus4.run       = run;
  assign bus4.step_mode = step_mode;

  simplez_seq #(.ICW(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  simplez_seq #(.ICW(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  logic [14:0] uo_obs;
  assign uo_obs = {bus.lec, bus.esc, bus.era, bus.eri, bus.sri, bus.incp,
                   bus.ecp, bus.ccp, bus.scp, bus.eac, bus.sac, bus.sum,
                   bus.tra2, bus.dec1, bus.bor};

  function automatic obs_t observe();
    return {bus.state, uo_obs, bus.stop, bus.icount, bus4.state, bus4.icount};
  endfunction

  function automatic obs_t expect_of(cyc_t c);
    return {c.st, c.uo, c.stop, exp_ic, c.st, exp_ic[3:0]};
  endfunction

  function automatic cyc_t cy(logic r, logic [2:0] op, logic az, logic rn,
                              logic stp, logic [2:0] st, logic [14:0] uo);
    cyc_t c;
    c.rst = r; c.op = op; c.az = az; c.run = rn; c.step = stp;
    c.st = st; c.uo = uo; c.stop = (st == S_HALTED);
    return c;
  endfunction

  function automatic void drive(cyc_t c);
    rst = c.rst; opcode = opcode_t'(c.op); ac_zero = c.az;
    run = c.run; step_mode = c.step;
  endfunction

  // Counter model: the cycle just checked decides the next expected icount
  function automatic void advance_model(cyc_t c);
    if (c.rst) exp_ic = '0;
    else if (c.st == S_I1) exp_ic = exp_ic + 16'd1;
  endfunction

  task automatic test_reset();
    cyc_t c;
    obs_t got, want;
    rst = 1'b1; opcode = OP_LD; run = 1'b1;
    repeat (2) @(negedge clk);
    exp_ic = '0;
    @(posedge clk); #1;
    c = cy(0, OP_LD, 0, 0, 0, S_INIT, CCP);
    drive(c);
    sb.push_back(expect_of(c));
    #1;
    got = observe(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL test_reset: got %h expected %h", got, want);
    end
    advance_model(c);
  endtask

  task automatic test_ld();
    cyc_t t[$];
    obs_t got, want;
    t.push_back(cy(0, OP_LD, 0, 0, 0, S_O1, SCP | ERA));
    t.push_back(cy(0, OP_LD, 0, 0, 0, S_I0, LEC | ERI | INCP));
    t.push_back(cy(0, OP_LD, 0, 0, 0, S_I1, SRI | ERA));
    t.push_back(cy(0, OP_LD, 0, 0, 0, S_O0, LEC | TRA2 | EAC));
    t.push_back(cy(0, OP_LD, 0, 0, 0, S_O1, SCP | ERA));
    foreach (t[i]) begin
      @(posedge clk); #1;
      drive(t[i]);
      sb.push_back(expect_of(t[i]));
      #1;
      got = observe(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL test_ld cycle %0d: got %h expected %h", i, got, want);
      end
      advance_model(t[i]);
    end
  endtask

  task automatic test_branch();
    cyc_t t[$];
    obs_t got, want;
    t.push_back(cy(0, OP_BZ, 1, 0, 0, S_I0, LEC | ERI | INCP));
    t.push_back(cy(0, OP_BZ, 1, 0, 0, S_I1, SRI | ERA | ECP));
    t.push_back(cy(0, OP_BZ, 0, 0, 0, S_I0, LEC | ERI | INCP));
    t.push_back(cy(0, OP_BZ, 0, 0, 0, S_I1, SCP | ERA));
    t.push_back(cy(0, OP_BR, 0, 0, 0, S_I0, LEC | ERI | INCP));
    t.push_back(cy(0, OP_BR, 0, 0, 0, S_I1, SRI | ERA | ECP));
    foreach (t[i]) begin
      @(posedge clk); #1;
      drive(t[i]);
      sb.push_back(expect_of(t[i]));
      #1;
      got = observe(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL test_branch cycle %0d: got %h expected %h", i, got, want);
      end
      advance_model(t[i]);
    end
  endtask

  // O0 must follow the fetched ADD even though the live opcode now reads HALT
  task automatic test_add_latched();
    cyc_t t[$];
    obs_t got, want;
    t.push_back(cy(0, OP_ADD,  0, 0, 0, S_I0, LEC | ERI | INCP));
    t.push_back(cy(0, OP_ADD,  0, 0, 0, S_I1, SRI | ERA));
    t.push_back(cy(0, OP_HALT, 0, 0, 0, S_O0, LEC | SUM | EAC));
    t.push_back(cy(0, OP_HALT, 0, 0, 0, S_O1, SCP | ERA));
    foreach (t[i]) begin
      @(posedge clk); #1;
      drive(t[i]);
      sb.push_back(expect_of(t[i]));
      #1;
      got = observe(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL test_add_latched cycle %0d: got %h expected %h", i, got, want);
      end
      advance_model(t[i]);
    end
  endtask

  task automatic test_halt();
    cyc_t t[$];
    obs_t got, want;
    // run during I0 must be ignored
    t.push_back(cy(0, OP_HALT, 0, 1, 0, S_I0, LEC | ERI | INCP));
    t.push_back(cy(0, OP_HALT, 0, 0, 0, S_I1, NONE));
    for (int k = 0; k < 10; k++) t.push_back(cy(0, OP_HALT, 0, 0, 0, S_HALTED, NONE));
    t.push_back(cy(0, OP_HALT, 0, 1, 0, S_HALTED, NONE));
    t.push_back(cy(0, OP_HALT, 0, 0, 0, S_O1, SCP | ERA));
    foreach (t[i]) begin
      @(posedge clk); #1;
      drive(t[i]);
      sb.push_back(expect_of(t[i]));
      #1;
      got = observe(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL test_halt cycle %0d: got %h expected %h", i, got, want);
      end
      advance_model(t[i]);
    end
  endtask

  task automatic test_step();
    cyc_t t[$];
    obs_t got, want;
    t.push_back(cy(0, OP_DEC, 0, 0, 1, S_I0, LEC | ERI | INCP));
    t.push_back(cy(0, OP_DEC, 0, 0, 1, S_I1, DEC1 | EAC | SCP | ERA));
    for (int k = 0; k < 3; k++) t.push_back(cy(0, OP_DEC, 0, 0, 1, S_PAUSE, NONE));
    t.push_back(cy(0, OP_DEC, 0, 1, 0, S_PAUSE, NONE));
    foreach (t[i]) begin
      @(posedge clk); #1;
      drive(t[i]);
      sb.push_back(expect_of(t[i]));
      #1;
      got = observe(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL test_step cycle %0d: got %h expected %h", i, got, want);
      end
      advance_model(t[i]);
    end
  endtask

  task automatic test_reset_mid_st();
    cyc_t t[$];
    obs_t got, want;
    t.push_back(cy(0, OP_ST, 0, 0, 0, S_I0, LEC | ERI | INCP));
    t.push_back(cy(0, OP_ST, 0, 0, 0, S_I1, SRI | ERA));
    t.push_back(cy(1, OP_ST, 0, 1, 0, S_O0, SAC | ESC));
    t.push_back(cy(0, OP_ST, 0, 0, 0, S_INIT, CCP));
    t.push_back(cy(0, OP_ST, 0, 0, 0, S_O1, SCP | ERA));
    foreach (t[i]) begin
      @(posedge clk); #1;
      drive(t[i]);
      sb.push_back(expect_of(t[i]));
      #1;
      got = observe(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL test_reset_mid_st cycle %0d: got %h expected %h", i, got, want);
      end
      advance_model(t[i]);
    end
  endtask

  // 16 CLRs from icount=0: the ICW=4 counter wraps 15 -> 0, ICW=16 reaches 16
  task automatic test_clr_wrap();
    cyc_t t[$];
    obs_t got, want;
    for (int k = 0; k < 16; k++) begin
      t.push_back(cy(0, OP_CLR, 0, 0, 0, S_I0, LEC | ERI | INCP));
      t.push_back(cy(0, OP_CLR, 0, 0, 0, S_I1, BOR | EAC | SCP | ERA));
    end
    t.push_back(cy(0, OP_CLR, 0, 0, 0, S_I0, LEC | ERI | INCP));
    foreach (t[i]) begin
      @(posedge clk); #1;
      drive(t[i]);
      sb.push_back(expect_of(t[i]));
      #1;
      got = observe(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL test_clr_wrap cycle %0d: got %h expected %h", i, got, want);
      end
      advance_model(t[i]);
    end
    checks++;
    if (bus4.icount !== 4'd0 || bus.icount !== 16'd16) begin
      errors++;
      $display("FAIL test_clr_wrap final icount: got %0d/%0d expected 16/0",
               bus.icount, bus4.icount);
    end
  endtask

  initial begin
    test_reset();
    test_ld();
    test_branch();
    test_add_latched();
    test_halt();
    test_step();
    test_reset_mid_st();
    test_clr_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_simplez_seq
`default_nettype wire
